// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and default constants for the SPI transaction scheduler.
//   slave_sel_t   : one-hot target select (MPU=001, SHREG=010, FLASH=100), SEL_NONE when idle
//   sched_state_t : scheduler FSM states
//   next_sel()    : round-robin successor of a one-hot target
package spi_txn_scheduler_pkg;

  localparam int unsigned SIZE_W_DEF      = 13;
  localparam int unsigned CNT_W_DEF       = 14;
  localparam int unsigned SVC_FLASH_R_DEF = 40;
  localparam int unsigned SVC_FLASH_W_DEF = 48;
  localparam int unsigned SVC_MPU_DEF     = 8;
  localparam int unsigned SVC_SHREG_DEF   = 0;
  localparam int unsigned GAP_CYCLES_DEF  = 4;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'b000,
    SEL_MPU   = 3'b001,
    SEL_SHREG = 3'b010,
    SEL_FLASH = 3'b100
  } slave_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // Requester that gets top priority after the given one has been served.
  function automatic slave_sel_t next_sel(input slave_sel_t s);
    slave_sel_t n;
    case (s)
      SEL_MPU:   n = SEL_SHREG;
      SEL_SHREG: n = SEL_FLASH;
      default:   n = SEL_MPU;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester/SPI-master bundle of the scheduler.
//   master modport : system-controller side (drives requests, observes grants and CS lines)
//   slave modport  : scheduler side (samples requests, drives grants, CS, size and mode)
// Bit order of all 3-bit vectors: [0]=MPU [1]=SHREG [2]=FLASH.
interface spi_txn_scheduler_if #(
  parameter int unsigned SIZE_W = 13
);
  logic [2:0]             req_i;
  logic [2:0]             nrw_i;
  logic [2:0][SIZE_W-1:0] size_i;
  logic [2:0]             gnt_o;
  logic [2:0]             done_o;
  logic [2:0]             abort_o;
  logic                   cs_mpu_o;
  logic                   cs_shift_reg_o;
  logic                   cs_flash_o;
  logic [SIZE_W-1:0]      data_size_o;
  logic                   master_mode_nrw_o;
  logic                   busy_o;

  modport master (
    output req_i, nrw_i, size_i,
    input  gnt_o, done_o, abort_o, cs_mpu_o, cs_shift_reg_o, cs_flash_o,
           data_size_o, master_mode_nrw_o, busy_o
  );

  modport slave (
    input  req_i, nrw_i, size_i,
    output gnt_o, done_o, abort_o, cs_mpu_o, cs_shift_reg_o, cs_flash_o,
           data_size_o, master_mode_nrw_o, busy_o
  );
endinterface

// File: rtl/spi_txn_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[2:0]    : request levels ([0]=MPU [1]=SHREG [2]=FLASH)
//   grant_en_i    : the pick is taken this cycle; pointer advances past the winner
//   pick_c        : combinational one-hot winner (SEL_NONE when no request)
module spi_rr_arbiter3
  import spi_txn_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       grant_en_i,
  output slave_sel_t pick_c
);

  // Highest-priority requester for the next arbitration.
  slave_sel_t ptr_q;

  // Fixed search order starting at the pointer.
  always_comb begin
    pick_c = SEL_NONE;
    case (ptr_q)
      SEL_SHREG: begin
        if (req_i[1])      pick_c = SEL_SHREG;
        else if (req_i[2]) pick_c = SEL_FLASH;
        else if (req_i[0]) pick_c = SEL_MPU;
      end
      SEL_FLASH: begin
        if (req_i[2])      pick_c = SEL_FLASH;
        else if (req_i[0]) pick_c = SEL_MPU;
        else if (req_i[1]) pick_c = SEL_SHREG;
      end
      default: begin
        if (req_i[0])      pick_c = SEL_MPU;
        else if (req_i[1]) pick_c = SEL_SHREG;
        else if (req_i[2]) pick_c = SEL_FLASH;
      end
    endcase
  end

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= SEL_MPU;
    end else if (grant_en_i && (pick_c != SEL_NONE)) begin
      ptr_q <= next_sel(pick_c);
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master between MPU, SHREG and FLASH requesters, one transaction at a time.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : req/nrw/size in; gnt/done/abort pulses, one-hot CS lines,
//                   data_size and master_mode_nrw to the master, busy out
// Flow: IDLE (arbitrate, latch) -> SETUP (load bit count) -> XFER (CS high for
// exactly size+service cycles) -> GAP (GAP_CYCLES with all CS low) -> IDLE.
module spi_txn_scheduler
  import spi_txn_scheduler_pkg::*;
#(
  parameter int unsigned SIZE_W      = SIZE_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SVC_FLASH_R = SVC_FLASH_R_DEF,
  parameter int unsigned SVC_FLASH_W = SVC_FLASH_W_DEF,
  parameter int unsigned SVC_MPU     = SVC_MPU_DEF,
  parameter int unsigned SVC_SHREG   = SVC_SHREG_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input logic                clk_i,
  input logic                rst_ni,
  spi_txn_scheduler_if.slave bus
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  sched_state_t      state_q;
  slave_sel_t        win_q;
  logic [SIZE_W-1:0] size_q;
  logic              nrw_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GAP_W-1:0]  gap_q;

  logic [2:0]        gnt_q;
  logic [2:0]        done_q;
  logic [2:0]        abort_q;
  logic [2:0]        cs_q;
  logic [SIZE_W-1:0] data_size_q;
  logic              mode_q;
  logic              busy_q;

  slave_sel_t        pick_c;
  logic [2:0]        pick_vec_c;
  logic [SIZE_W-1:0] pick_size_c;
  logic              pick_nrw_c;
  logic              pick_mode_c;
  logic              win_req_c;
  logic [CNT_W-1:0]  svc_c;
  logic [CNT_W-1:0]  cnt_load_c;

  spi_rr_arbiter3 u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (bus.req_i),
    .grant_en_i (state_q == ST_IDLE),
    .pick_c     (pick_c)
  );

  assign pick_vec_c = pick_c;

  // Size/direction of the arbitration winner.
  always_comb begin
    pick_size_c = '0;
    pick_nrw_c  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pick_vec_c[i]) begin
        pick_size_c = bus.size_i[i];
        pick_nrw_c  = bus.nrw_i[i];
      end
    end
  end

  // Only FLASH has a selectable direction; MPU always reads, SHREG always writes.
  always_comb begin
    pick_mode_c = 1'b0;
    case (pick_c)
      SEL_FLASH: pick_mode_c = pick_nrw_c;
      SEL_SHREG: pick_mode_c = 1'b1;
      default:   pick_mode_c = 1'b0;
    endcase
  end

  // Service overhead of the latched target; payload bits are added on top.
  always_comb begin
    svc_c = '0;
    case (win_q)
      SEL_FLASH: svc_c = nrw_q ? CNT_W'(SVC_FLASH_W) : CNT_W'(SVC_FLASH_R);
      SEL_MPU:   svc_c = CNT_W'(SVC_MPU);
      SEL_SHREG: svc_c = CNT_W'(SVC_SHREG);
      default:   svc_c = '0;
    endcase
  end

  assign cnt_load_c = CNT_W'(size_q) + svc_c;
  assign win_req_c  = |(bus.req_i & win_q);

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      win_q       <= SEL_NONE;
      size_q      <= '0;
      nrw_q       <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      abort_q     <= '0;
      cs_q        <= '0;
      data_size_q <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q  <= '0;
      abort_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_c != SEL_NONE) begin
            state_q     <= ST_SETUP;
            win_q       <= pick_c;
            size_q      <= pick_size_c;
            nrw_q       <= pick_mode_c;
            gnt_q       <= pick_vec_c;
            data_size_q <= pick_size_c;
            mode_q      <= pick_mode_c;
            busy_q      <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (!win_req_c || (cnt_load_c == '0)) begin
            // Dropped request aborts; an empty transaction completes without CS.
            state_q     <= ST_GAP;
            gap_q       <= GAP_W'(GAP_CYCLES - 1);
            gnt_q       <= '0;
            data_size_q <= '0;
            mode_q      <= 1'b0;
            if (!win_req_c) abort_q <= win_q;
            else            done_q  <= win_q;
          end else begin
            state_q <= ST_XFER;
            cnt_q   <= cnt_load_c;
            cs_q    <= win_q;
          end
        end

        ST_XFER: begin
          if (!win_req_c || (cnt_q == CNT_W'(1))) begin
            state_q     <= ST_GAP;
            gap_q       <= GAP_W'(GAP_CYCLES - 1);
            gnt_q       <= '0;
            cs_q        <= '0;
            data_size_q <= '0;
            mode_q      <= 1'b0;
            if (!win_req_c) abort_q <= win_q;
            else            done_q  <= win_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt_o             = gnt_q;
  assign bus.done_o            = done_q;
  assign bus.abort_o           = abort_q;
  assign bus.cs_mpu_o          = cs_q[0];
  assign bus.cs_shift_reg_o    = cs_q[1];
  assign bus.cs_flash_o        = cs_q[2];
  assign bus.data_size_o       = data_size_q;
  assign bus.master_mode_nrw_o = mode_q;
  assign bus.busy_o            = busy_q;

  // Never more than one chip select active.
  cs_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(cs_q));

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed self-checking bench for spi_txn_scheduler.
module tb_spi_txn_scheduler;
  logic clk_i;
  logic rst_ni;
  int   pass_cnt;
  int   total_cnt;

  spi_txn_scheduler_if #(.SIZE_W(13)) bus ();

  spi_txn_scheduler dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (!bus.busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_i  = '0;
    bus.nrw_i  = '0;
    bus.size_i = '0;
    rst_ni     = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.gnt_o !== 3'b000) $display("FAIL rst_gnt: got %b want 000", bus.gnt_o); else pass_cnt++;
    total_cnt++; if (bus.done_o !== 3'b000 || bus.abort_o !== 3'b000) $display("FAIL rst_pulses: done %b abort %b want 000", bus.done_o, bus.abort_o); else pass_cnt++;
    total_cnt++; if ({bus.cs_flash_o, bus.cs_shift_reg_o, bus.cs_mpu_o} !== 3'b000) $display("FAIL rst_cs: got %b want 000", {bus.cs_flash_o, bus.cs_shift_reg_o, bus.cs_mpu_o}); else pass_cnt++;
    total_cnt++; if (bus.data_size_o !== 13'd0 || bus.master_mode_nrw_o !== 1'b0) $display("FAIL rst_size_mode: size %0d mode %b want 0 0", bus.data_size_o, bus.master_mode_nrw_o); else pass_cnt++;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_flash_read();
    int n;
    bit other;
    bus.nrw_i[2]  = 1'b0;
    bus.size_i[2] = 13'd8;
    bus.req_i[2]  = 1'b1;
    tick();
    total_cnt++; if (bus.gnt_o !== 3'b100) $display("FAIL fr_setup_gnt: got %b want 100", bus.gnt_o); else pass_cnt++;
    total_cnt++; if (bus.data_size_o !== 13'd8 || bus.master_mode_nrw_o !== 1'b0) $display("FAIL fr_setup_size_mode: size %0d mode %b want 8 0", bus.data_size_o, bus.master_mode_nrw_o); else pass_cnt++;
    total_cnt++; if (bus.cs_flash_o !== 1'b0 || bus.busy_o !== 1'b1) $display("FAIL fr_setup_cs_busy: cs %b busy %b want 0 1", bus.cs_flash_o, bus.busy_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.cs_flash_o !== 1'b1) $display("FAIL fr_cs_latency: cs_flash %b want 1 two cycles after req", bus.cs_flash_o); else pass_cnt++;
    n = 0;
    other = 1'b0;
    while (bus.cs_flash_o === 1'b1 && n < 20000) begin
      n++;
      if (bus.cs_mpu_o || bus.cs_shift_reg_o) other = 1'b1;
      tick();
    end
    total_cnt++; if (n !== 48) $display("FAIL fr_cs_len: got %0d want 48", n); else pass_cnt++;
    total_cnt++; if (other !== 1'b0) $display("FAIL fr_other_cs: got %b want 0", other); else pass_cnt++;
    total_cnt++; if (bus.done_o !== 3'b100 || bus.gnt_o !== 3'b000) $display("FAIL fr_done: done %b gnt %b want 100 000", bus.done_o, bus.gnt_o); else pass_cnt++;
    bus.req_i[2] = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (bus.busy_o !== 1'b1 || bus.done_o !== 3'b000) $display("FAIL fr_gap_end: busy %b done %b want 1 000", bus.busy_o, bus.done_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL fr_idle_busy: got %b want 0", bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [2:0] order [3];
    logic [2:0] last_gnt;
    logic [2:0] cs;
    int order_n, low_run, min_gap, dones;
    bit seen_cs, overlap, ok;
    pulse_reset();
    bus.size_i[0] = 13'd2;
    bus.size_i[1] = 13'd4;
    bus.size_i[2] = 13'd1;
    bus.nrw_i     = 3'b000;
    bus.req_i     = 3'b111;
    order_n = 0; low_run = 0; min_gap = 1000; dones = 0;
    seen_cs = 1'b0; overlap = 1'b0; last_gnt = 3'b000;
    for (int i = 0; i < 3; i++) order[i] = 3'b000;
    for (int c = 0; c < 600 && dones < 3; c++) begin
      tick();
      cs = {bus.cs_flash_o, bus.cs_shift_reg_o, bus.cs_mpu_o};
      if (!$onehot0(cs)) overlap = 1'b1;
      if (cs == 3'b000) begin
        low_run++;
      end else begin
        if (seen_cs && low_run > 0 && low_run < min_gap) min_gap = low_run;
        low_run = 0;
        seen_cs = 1'b1;
      end
      if (bus.gnt_o != 3'b000 && bus.gnt_o != last_gnt) begin
        if (order_n < 3) order[order_n] = bus.gnt_o;
        order_n++;
      end
      last_gnt = bus.gnt_o;
      if (bus.done_o != 3'b000) begin
        dones++;
        bus.req_i = bus.req_i & ~bus.done_o;
      end
    end
    total_cnt++; if (dones !== 3 || order_n !== 3) $display("FAIL rr_count: dones %0d grants %0d want 3 3", dones, order_n); else pass_cnt++;
    total_cnt++; if (order[0] !== 3'b001 || order[1] !== 3'b010 || order[2] !== 3'b100) $display("FAIL rr_order: got %b %b %b want 001 010 100", order[0], order[1], order[2]); else pass_cnt++;
    total_cnt++; if (overlap !== 1'b0) $display("FAIL rr_overlap: got %b want 0", overlap); else pass_cnt++;
    total_cnt++; if (min_gap < 4 || min_gap > 6) $display("FAIL rr_gap: got %0d want 4..6", min_gap); else pass_cnt++;
    wait_idle(ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL rr_idle: busy stuck %b want 0", bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_zero_size();
    bit ok;
    bus.size_i[1] = 13'd0;
    bus.req_i[1]  = 1'b1;
    tick();
    total_cnt++; if (bus.gnt_o !== 3'b010 || bus.data_size_o !== 13'd0) $display("FAIL zs_setup: gnt %b size %0d want 010 0", bus.gnt_o, bus.data_size_o); else pass_cnt++;
    total_cnt++; if (bus.cs_shift_reg_o !== 1'b0) $display("FAIL zs_setup_cs: got %b want 0", bus.cs_shift_reg_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.done_o !== 3'b010 || bus.cs_shift_reg_o !== 1'b0 || bus.gnt_o !== 3'b000) $display("FAIL zs_done: done %b cs %b gnt %b want 010 0 000", bus.done_o, bus.cs_shift_reg_o, bus.gnt_o); else pass_cnt++;
    bus.req_i[1] = 1'b0;
    tick();
    total_cnt++; if (bus.done_o !== 3'b000 || bus.cs_shift_reg_o !== 1'b0) $display("FAIL zs_one_cycle: done %b cs %b want 000 0", bus.done_o, bus.cs_shift_reg_o); else pass_cnt++;
    wait_idle(ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL zs_idle: busy stuck %b want 0", bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_abort();
    bit ok, saw_done;
    bus.size_i[0] = 13'd8;
    bus.req_i[0]  = 1'b1;
    tick();
    tick();
    tick(); tick(); tick(); tick();
    total_cnt++; if (bus.cs_mpu_o !== 1'b1) $display("FAIL ab_cs_c5: got %b want 1", bus.cs_mpu_o); else pass_cnt++;
    bus.req_i[0] = 1'b0;
    tick();
    total_cnt++; if (bus.cs_mpu_o !== 1'b0) $display("FAIL ab_cs_drop: got %b want 0", bus.cs_mpu_o); else pass_cnt++;
    total_cnt++; if (bus.abort_o !== 3'b001 || bus.done_o !== 3'b000) $display("FAIL ab_pulse: abort %b done %b want 001 000", bus.abort_o, bus.done_o); else pass_cnt++;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done_o != 3'b000 || bus.abort_o != 3'b000) saw_done = 1'b1;
    end
    total_cnt++; if (saw_done !== 1'b0 || bus.busy_o !== 1'b0) $display("FAIL ab_after: extra pulse %b busy %b want 0 0", saw_done, bus.busy_o); else pass_cnt++;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    bit ok;
    bus.size_i[0] = 13'd8;
    bus.req_i[0]  = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 9; c++) tick();
    total_cnt++; if (bus.cs_mpu_o !== 1'b1) $display("FAIL rx_cs_c10: got %b want 1", bus.cs_mpu_o); else pass_cnt++;
    rst_ni = 1'b0;
    #1;
    total_cnt++; if ({bus.cs_flash_o, bus.cs_shift_reg_o, bus.cs_mpu_o, bus.gnt_o, bus.busy_o, bus.done_o, bus.abort_o} !== 13'd0 || bus.data_size_o !== 13'd0) $display("FAIL rx_async: cs %b gnt %b busy %b done %b abort %b size %0d want all 0", {bus.cs_flash_o, bus.cs_shift_reg_o, bus.cs_mpu_o}, bus.gnt_o, bus.busy_o, bus.done_o, bus.abort_o, bus.data_size_o); else pass_cnt++;
    tick();
    rst_ni = 1'b1;
    tick();
    total_cnt++; if (bus.gnt_o !== 3'b001 || bus.cs_mpu_o !== 1'b0) $display("FAIL rx_restart_setup: gnt %b cs %b want 001 0", bus.gnt_o, bus.cs_mpu_o); else pass_cnt++;
    tick();
    n = 0;
    while (bus.cs_mpu_o === 1'b1 && n < 20000) begin
      n++;
      tick();
    end
    total_cnt++; if (n !== 16) $display("FAIL rx_restart_len: got %0d want 16", n); else pass_cnt++;
    total_cnt++; if (bus.done_o !== 3'b001) $display("FAIL rx_done: got %b want 001", bus.done_o); else pass_cnt++;
    bus.req_i[0] = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_flash_write_max();
    int n;
    bit other, ok;
    logic [12:0] ds_mid;
    bus.nrw_i[2]  = 1'b1;
    bus.size_i[2] = 13'd8191;
    bus.req_i[2]  = 1'b1;
    tick();
    total_cnt++; if (bus.data_size_o !== 13'd8191 || bus.master_mode_nrw_o !== 1'b1) $display("FAIL fw_setup: size %0d mode %b want 8191 1", bus.data_size_o, bus.master_mode_nrw_o); else pass_cnt++;
    tick();
    n = 0;
    other = 1'b0;
    ds_mid = '0;
    while (bus.cs_flash_o === 1'b1 && n < 20000) begin
      n++;
      if (n == 100) bus.size_i[2] = 13'd5;
      if (n == 200) bus.req_i[1] = 1'b1;
      if (n == 210) bus.req_i[1] = 1'b0;
      if (n == 8000) ds_mid = bus.data_size_o;
      if (bus.cs_mpu_o || bus.cs_shift_reg_o) other = 1'b1;
      tick();
    end
    total_cnt++; if (n !== 8239) $display("FAIL fw_cs_len: got %0d want 8239", n); else pass_cnt++;
    total_cnt++; if (ds_mid !== 13'd8191) $display("FAIL fw_size_stable: got %0d want 8191", ds_mid); else pass_cnt++;
    total_cnt++; if (other !== 1'b0 || bus.done_o !== 3'b100) $display("FAIL fw_done: other_cs %b done %b want 0 100", other, bus.done_o); else pass_cnt++;
    bus.req_i[2] = 1'b0;
    wait_idle(ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL fw_idle: busy stuck %b want 0", bus.busy_o); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_flash_read();
    test_round_robin();
    test_zero_size();
    test_abort();
    test_reset_mid_xfer();
    test_flash_write_max();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
